// File: rtl/microcode_sequencer.sv
// microcode_sequencer: free-running micro-PC sequencer that sits between the
// instruction register and the microcode ROM. Each microword carries its own
// next-address control (SEQ/JMP/DISP/END) and a memory-wait hold bit. The
// block also handles interrupt entry at instruction boundaries, fault entry,
// HALT, and a per-instruction step watchdog.
module microcode_sequencer #(
    parameter int             OPW           = 6,
    parameter int             UAW           = 8,
    parameter int             UWW           = 48,
    parameter int             FETCH_ADDR    = 2,
    parameter int             IRQ_ADDR      = 240,
    parameter int             FAULT_ADDR    = 248,
    parameter int             DISPATCH_BASE = 0,
    parameter logic [OPW-1:0] HALT_OPCODE   = OPW'('h3f),
    parameter int             STEP_LIMIT    = 64,
    localparam int            CW            = UWW - 4 - UAW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode_in,
    input  logic [UWW-1:0] uword,
    output logic [UAW-1:0] uaddr,
    output logic [CW-1:0]  ctrl,
    output logic           step_done,
    output logic           instr_end,
    input  logic           cond_in,
    input  logic           mem_ack,
    input  logic           irq,
    output logic           irq_ack,
    input  logic           fault,
    output logic           timeout,
    output logic           halted
);

    localparam int CNTW = $clog2(STEP_LIMIT + 1);

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        SEQ_NEXT = 2'd0,
        SEQ_JMP  = 2'd1,
        SEQ_DISP = 2'd2,
        SEQ_END  = 2'd3
    } seq_t;

    state_t          r_state;
    logic [UAW-1:0]  r_upc;
    logic [CNTW-1:0] r_stepCnt;
    logic            r_irqPend;

    state_t          w_nextState;
    logic [UAW-1:0]  w_nextUpc;
    logic [CNTW-1:0] w_nextCnt;
    logic            w_nextPend;

    seq_t            w_seq;
    logic            w_cond;
    logic            w_wait;
    logic [UAW-1:0]  w_target;
    logic [CW-1:0]   w_ctrlField;
    logic            w_run;
    logic            w_isEnd;
    logic            w_irqTake;
    logic            w_wdFire;
    logic            w_jmpTaken;
    logic [UAW-1:0]  w_upcInc;
    logic [UAW-1:0]  w_dispAddr;

    // Microword field extraction
    assign w_seq       = seq_t'(uword[UWW-1 -: 2]);
    assign w_cond      = uword[UWW-3];
    assign w_wait      = uword[UWW-4];
    assign w_target    = uword[UWW-5 -: UAW];
    assign w_ctrlField = uword[CW-1:0];

    // Step qualification: no strobes while in reset or HALT, fault kills the step
    assign w_run      = (r_state == ST_RUN) && !reset;
    assign step_done  = w_run && !fault && !(w_wait && !mem_ack);
    assign w_isEnd    = (w_seq == SEQ_END);
    assign w_irqTake  = r_irqPend || irq;
    assign instr_end  = step_done && w_isEnd;
    assign irq_ack    = instr_end && w_irqTake;
    assign w_wdFire   = step_done && !w_isEnd && (r_stepCnt == CNTW'(STEP_LIMIT - 1));
    assign timeout    = w_wdFire;
    assign w_jmpTaken = !w_cond || cond_in;
    assign w_upcInc   = r_upc + UAW'(1);
    assign w_dispAddr = UAW'(DISPATCH_BASE) + UAW'(opcode_in);

    assign uaddr  = r_upc;
    assign ctrl   = w_run ? w_ctrlField : '0;
    assign halted = (r_state == ST_HALT);

    // Next-state logic: HALT freezes everything, fault beats watchdog beats sequencing
    always_comb begin
        w_nextState = r_state;
        w_nextUpc   = r_upc;
        w_nextCnt   = r_stepCnt;
        w_nextPend  = w_irqTake;
        if (r_state == ST_HALT) begin
            w_nextState = ST_HALT;
        end else if (fault) begin
            w_nextUpc = UAW'(FAULT_ADDR);
            w_nextCnt = '0;
        end else if (step_done) begin
            if (w_wdFire) begin
                w_nextUpc = UAW'(FAULT_ADDR);
                w_nextCnt = '0;
            end else begin
                if (w_isEnd) begin
                    w_nextCnt = '0;
                end else begin
                    w_nextCnt = r_stepCnt + CNTW'(1);
                end
                case (w_seq)
                    SEQ_NEXT: w_nextUpc = w_upcInc;
                    SEQ_JMP:  w_nextUpc = w_jmpTaken ? w_target : w_upcInc;
                    SEQ_DISP: begin
                        if (opcode_in == HALT_OPCODE) begin
                            w_nextState = ST_HALT;
                        end else begin
                            w_nextUpc = w_dispAddr;
                        end
                    end
                    SEQ_END: begin
                        if (w_irqTake) begin
                            w_nextUpc  = UAW'(IRQ_ADDR);
                            w_nextPend = 1'b0;
                        end else begin
                            w_nextUpc = UAW'(FETCH_ADDR);
                        end
                    end
                    default: w_nextUpc = w_upcInc;
                endcase
            end
        end
    end

    // State register with synchronous reset into RUN at the fetch routine
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_upc     <= UAW'(FETCH_ADDR);
            r_stepCnt <= '0;
            r_irqPend <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_upc     <= w_nextUpc;
            r_stepCnt <= w_nextCnt;
            r_irqPend <= w_nextPend;
        end
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// tb_microcode_sequencer: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model of the
// sequencer that walks the ROM contents held in the bench.
module tb_microcode_sequencer;

    localparam int STEP_LIMIT = 4;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode_in;
    logic [47:0] uword;
    logic [7:0]  uaddr;
    logic [35:0] ctrl;
    logic        step_done;
    logic        instr_end;
    logic        cond_in;
    logic        mem_ack;
    logic        irq;
    logic        irq_ack;
    logic        fault;
    logic        timeout;
    logic        halted;

    logic [47:0] rom [256];

    int checks = 0;
    int errors = 0;

    // Model state
    int mUpc;
    int mSteps;
    bit mHalted;
    bit mPend;
    bit mValid = 1'b0;

    microcode_sequencer #(.STEP_LIMIT(STEP_LIMIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode_in (opcode_in),
        .uword     (uword),
        .uaddr     (uaddr),
        .ctrl      (ctrl),
        .step_done (step_done),
        .instr_end (instr_end),
        .cond_in   (cond_in),
        .mem_ack   (mem_ack),
        .irq       (irq),
        .irq_ack   (irq_ack),
        .fault     (fault),
        .timeout   (timeout),
        .halted    (halted)
    );

    assign uword = rom[uaddr];

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [47:0] mkWord(int seq, bit cnd, bit wt, int tgt, logic [35:0] ctl);
        return {2'(seq), cnd, wt, 8'(tgt), ctl};
    endfunction

    task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(bit r, bit i, bit f, bit a, bit c, logic [5:0] op);
        reset     = r;
        irq       = i;
        fault     = f;
        mem_ack   = a;
        cond_in   = c;
        opcode_in = op;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
        tick();
        tick();
        checkOutput("rst_uaddr", uaddr, 8'd2);
        checkOutput("rst_halted", halted, 1'b0);
        checkOutput("rst_ctrl", ctrl, 36'd0);
        checkOutput("rst_done", step_done, 1'b0);
        checkOutput("rst_timeout", timeout, 1'b0);
        checkOutput("rst_irqack", irq_ack, 1'b0);
    endtask

    task automatic clearRom();
        for (int k = 0; k < 256; k++) rom[k] = mkWord(0, 1'b0, 1'b0, 0, 36'd0);
    endtask

    // Reference model: compares outputs mid-cycle, then advances to the post-edge state
    always @(negedge clk) begin
        logic [47:0] w;
        int  seq;
        bit  cnd, wt, run, expDone, expEnd, expTo, expAck, pendNow;
        int  tgt;
        logic [35:0] ctl;
        w   = rom[mUpc & 255];
        seq = int'(w[47:46]);
        cnd = w[45];
        wt  = w[44];
        tgt = int'(w[43:36]);
        ctl = w[35:0];
        if (!mValid) begin
            if (reset === 1'b1) begin
                mValid = 1'b1;
                mUpc = 2; mHalted = 1'b0; mPend = 1'b0; mSteps = 0;
            end
        end else begin
            run     = !reset && !mHalted;
            expDone = run && !fault && (!wt || mem_ack);
            pendNow = mPend || irq;
            expEnd  = expDone && (seq == 3);
            expTo   = expDone && (seq != 3) && (mSteps + 1 == STEP_LIMIT);
            expAck  = expEnd && pendNow;
            checkOutput("uaddr", uaddr, 64'(mUpc));
            checkOutput("halted", halted, mHalted);
            checkOutput("ctrl", ctrl, run ? ctl : 36'd0);
            checkOutput("step_done", step_done, expDone);
            checkOutput("instr_end", instr_end, expEnd);
            checkOutput("irq_ack", irq_ack, expAck);
            checkOutput("timeout", timeout, expTo);
            if (reset) begin
                mUpc = 2; mHalted = 1'b0; mPend = 1'b0; mSteps = 0;
            end else if (mHalted) begin
                mPend = pendNow;
            end else if (fault) begin
                mUpc = 248; mSteps = 0; mPend = pendNow;
            end else if (expDone) begin
                mPend = pendNow;
                if (expTo) begin
                    mUpc = 248; mSteps = 0;
                end else begin
                    mSteps = mSteps + 1;
                    case (seq)
                        0: mUpc = (mUpc + 1) % 256;
                        1: mUpc = (!cnd || cond_in) ? tgt : (mUpc + 1) % 256;
                        2: if (opcode_in == 6'h3f) mHalted = 1'b1;
                           else mUpc = int'(opcode_in) % 256;
                        default: begin
                            mSteps = 0;
                            mUpc   = pendNow ? 240 : 2;
                            mPend  = 1'b0;
                        end
                    endcase
                end
            end else begin
                mPend = pendNow;
            end
        end
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        logic [63:0] rnd;
        clearRom();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0);

        // SEQ, SEQ, DISP(5), END
        rom[2] = mkWord(0, 1'b0, 1'b0, 0, 36'h1111);
        rom[3] = mkWord(0, 1'b0, 1'b0, 0, 36'h2222);
        rom[4] = mkWord(2, 1'b0, 1'b0, 0, 36'h3333);
        rom[5] = mkWord(3, 1'b0, 1'b0, 0, 36'h4444);
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd5);
        checkOutput("A_uaddr2", uaddr, 8'd2);
        checkOutput("A_ctrl2", ctrl, 36'h1111);
        checkOutput("A_done2", step_done, 1'b1);
        tick();
        checkOutput("A_uaddr3", uaddr, 8'd3);
        tick();
        checkOutput("A_uaddr4", uaddr, 8'd4);
        checkOutput("A_ctrl4", ctrl, 36'h3333);
        tick();
        checkOutput("A_uaddr5", uaddr, 8'd5);
        checkOutput("A_end5", instr_end, 1'b1);
        tick();
        checkOutput("A_fetch", uaddr, 8'd2);

        // WAIT step held for three cycles without mem_ack
        clearRom();
        rom[2] = mkWord(0, 1'b0, 1'b1, 0, 36'hABCDE);
        rom[3] = mkWord(3, 1'b0, 1'b0, 0, 36'd0);
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
            checkOutput("B_hold_uaddr", uaddr, 8'd2);
            checkOutput("B_hold_done", step_done, 1'b0);
            checkOutput("B_hold_ctrl", ctrl, 36'hABCDE);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
        checkOutput("B_ack_done", step_done, 1'b1);
        tick();
        checkOutput("B_next", uaddr, 8'd3);

        // Conditional jump not taken then taken
        clearRom();
        rom[2]    = mkWord(1, 1'b1, 1'b0, 8'h20, 36'd1);
        rom[3]    = mkWord(1, 1'b1, 1'b0, 8'h20, 36'd2);
        rom[8'h20] = mkWord(3, 1'b0, 1'b0, 0, 36'd3);
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
        tick();
        checkOutput("C_nottaken", uaddr, 8'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0);
        tick();
        checkOutput("C_taken", uaddr, 8'h20);

        // Interrupt latched mid-instruction, taken at END only once
        clearRom();
        rom[2]   = mkWord(0, 1'b0, 1'b0, 0, 36'd0);
        rom[3]   = mkWord(3, 1'b0, 1'b0, 0, 36'd0);
        rom[240] = mkWord(3, 1'b0, 1'b0, 0, 36'd0);
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0);
        checkOutput("D_noack_mid", irq_ack, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
        checkOutput("D_ack", irq_ack, 1'b1);
        tick();
        checkOutput("D_irqentry", uaddr, 8'd240);
        checkOutput("D_ack_once", irq_ack, 1'b0);
        tick();
        checkOutput("D_refetch", uaddr, 8'd2);

        // Fault during a WAIT, then fault colliding with END
        clearRom();
        rom[2] = mkWord(0, 1'b0, 1'b1, 0, 36'd7);
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
        checkOutput("E_done", step_done, 1'b0);
        tick();
        checkOutput("E_fault", uaddr, 8'd248);
        rom[2] = mkWord(3, 1'b0, 1'b0, 0, 36'd7);
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0);
        checkOutput("E_end_blocked", instr_end, 1'b0);
        checkOutput("E_ack_blocked", irq_ack, 1'b0);
        tick();
        checkOutput("E_end_fault", uaddr, 8'd248);

        // Watchdog on a jump-to-self loop
        clearRom();
        rom[2] = mkWord(1, 1'b0, 1'b0, 2, 36'd9);
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
            checkOutput("F_no_timeout", timeout, 1'b0);
            tick();
            checkOutput("F_loop", uaddr, 8'd2);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
        checkOutput("F_timeout", timeout, 1'b1);
        tick();
        checkOutput("F_wd_fault", uaddr, 8'd248);

        // Micro-PC wrap on SEQ
        clearRom();
        rom[2]   = mkWord(1, 1'b0, 1'b0, 255, 36'd0);
        rom[255] = mkWord(0, 1'b0, 1'b0, 0, 36'd0);
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
        tick();
        checkOutput("G_top", uaddr, 8'd255);
        tick();
        checkOutput("G_wrap", uaddr, 8'd0);

        // HALT via dispatch, ignores irq/fault, exits only on reset
        clearRom();
        rom[2] = mkWord(2, 1'b0, 1'b0, 0, 36'h55);
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h3f);
        checkOutput("H_disp_done", step_done, 1'b1);
        tick();
        checkOutput("H_halted", halted, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0);
        checkOutput("H_ctrl0", ctrl, 36'd0);
        checkOutput("H_done0", step_done, 1'b0);
        tick();
        tick();
        checkOutput("H_frozen", uaddr, 8'd2);
        checkOutput("H_still", halted, 1'b1);
        doReset();

        // Randomized traffic over a random microprogram
        for (int k = 0; k < 256; k++) begin
            rnd = {$urandom(), $urandom()};
            rom[k] = mkWord($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                            $urandom_range(0, 3) == 0, $urandom_range(0, 255), rnd[35:0]);
        end
        doReset();
        for (int k = 0; k < 3000; k++) begin
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0,
                          $urandom_range(0, 31) == 0, $urandom_range(0, 9) < 6,
                          1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
